// File: rtl/vliw_pkg.sv
// Shared VLIW front-end definitions: pack geometry, refill state encoding and
// the beat address helper reused by the instruction and data refill engines.
package vliw_pkg;

  localparam int PC_W       = 28;
  localparam int PACK_W     = 128;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = 4;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int ADDR_W     = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    COMMIT = ST_COMMIT
  } refill_state_e;

  // The top nibble is fixed by the region; the pack address above it is
  // simply truncated, so incrementing the beat can never carry into it.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [3:0]            hi,
    input logic [PC_W-5:0]       pc_lo,
    input logic [BEAT_IDX_W-1:0] beat
  );
    return {hi, pc_lo, beat, 2'b00};
  endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Bundle of fetch-side, memory-side and icache-install signals seen by the
// instruction-cache refill engine.
interface icache_refill_if
  import vliw_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic                  fetch_req;
  logic [PC_W-1:0]       curr_PC;
  logic                  cache_hit;
  logic                  invalidate;

  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ack;
  logic [BEAT_W-1:0]     mem_rdata;

  logic [PACK_W-1:0]     new_entry;
  logic                  entry_valid;
  logic                  refill_busy;
  logic [CNT_W-1:0]      miss_count;

  modport master (
    input  fetch_req, curr_PC, cache_hit, invalidate, mem_ack, mem_rdata,
    output mem_req, mem_addr, new_entry, entry_valid, refill_busy, miss_count
  );

  modport slave (
    output fetch_req, curr_PC, cache_hit, invalidate, mem_ack, mem_rdata,
    input  mem_req, mem_addr, new_entry, entry_valid, refill_busy, miss_count
  );

endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: on a fetch miss, reads a 128-bit pack as
// four 32-bit beats and offers it to the icache with a one-cycle strobe.
module icache_refill
  import vliw_pkg::*;
#(
  parameter logic [3:0] ADDR_HI = 4'h0,
  parameter int         CNT_W   = 16
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  icache_refill_if.master bus
);

  refill_state_e         state_reg;
  logic [PC_W-1:0]       pc_reg;
  logic [BEAT_IDX_W-1:0] beat_reg;
  logic                  abort_reg;
  logic                  cooldown_reg;
  logic                  mem_req_reg;
  logic [ADDR_W-1:0]     mem_addr_reg;
  logic [CNT_W-1:0]      miss_count_reg;

  logic                  miss_detect;
  logic                  beat_ack;
  logic                  last_beat;
  logic                  pc_moved;
  logic [BEATS-1:0]      lane_we;
  logic [PACK_W-1:0]     pack;

  always_comb begin
    miss_detect = bus.fetch_req && !bus.cache_hit && !bus.invalidate;
    beat_ack    = (state_reg == FETCH) && mem_req_reg && bus.mem_ack;
    last_beat   = (beat_reg == BEAT_IDX_W'(BEATS - 1));
    pc_moved    = (bus.curr_PC != pc_reg);
  end

  // Beat assembler: each 32-bit lane loads only on the ack of its own beat.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      logic [BEAT_W-1:0] word_reg;

      assign lane_we[gi] = beat_ack && (beat_reg == BEAT_IDX_W'(gi));

      always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (lane_we[gi]) begin
          word_reg <= bus.mem_rdata;
        end
      end

      assign pack[gi*BEAT_W +: BEAT_W] = word_reg;
    end
  endgenerate

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      beat_reg       <= '0;
      abort_reg      <= 1'b0;
      cooldown_reg   <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      miss_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The icache only reports the freshly installed pack one cycle
          // after COMMIT, so the first IDLE cycle ignores fetch requests.
          if (cooldown_reg) begin
            cooldown_reg <= 1'b0;
          end else if (miss_detect) begin
            pc_reg       <= bus.curr_PC;
            beat_reg     <= '0;
            abort_reg    <= 1'b0;
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= beat_addr(ADDR_HI, bus.curr_PC[PC_W-5:0], '0);
            if (miss_count_reg != '1) begin
              miss_count_reg <= miss_count_reg + 1'b1;
            end
            state_reg    <= FETCH;
          end
        end

        FETCH: begin
          // Never cut the bus transfer; just remember the pack is stale.
          if (bus.invalidate || pc_moved) begin
            abort_reg <= 1'b1;
          end
          if (beat_ack) begin
            if (last_beat) begin
              mem_req_reg <= 1'b0;
              state_reg   <= COMMIT;
            end else begin
              beat_reg     <= beat_reg + 1'b1;
              mem_addr_reg <= beat_addr(ADDR_HI, pc_reg[PC_W-5:0], beat_reg + 1'b1);
            end
          end
        end

        COMMIT: begin
          beat_reg     <= '0;
          cooldown_reg <= 1'b1;
          state_reg    <= IDLE;
        end

        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  // The install strobe must also reflect the fetch PC and flush seen in the
  // COMMIT cycle itself, hence it is decoded rather than registered.
  assign bus.entry_valid = (state_reg == COMMIT) && !abort_reg && !pc_moved
                           && !bus.invalidate;
  assign bus.mem_req     = mem_req_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.new_entry   = pack;
  assign bus.refill_busy = (state_reg != IDLE);
  assign bus.miss_count  = miss_count_reg;

endmodule
